// File: rtl/nios2_pio_pkg.sv
// Shared register map, pulse FSM state type and STATUS field positions
// for the NIOS2 output PIO.
package nios2_pio_pkg;

    localparam logic [2:0] ADDR_DATA   = 3'd0;
    localparam logic [2:0] ADDR_PLEN   = 3'd1;
    localparam logic [2:0] ADDR_PULSE  = 3'd2;
    localparam logic [2:0] ADDR_OUTSET = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR = 3'd5;

    typedef enum logic {
        IDLE  = 1'b0,
        PULSE = 1'b1
    } pulse_state_e;

    // STATUS word: down-counter in the low bits, busy flag in the MSB.
    localparam int unsigned STATUS_CNT_LSB = 0;

    function automatic int unsigned status_busy_bit(input int unsigned data_width);
        return data_width - 1;
    endfunction

endpackage

// File: rtl/nios2_pio_pulse_timer.sv
// One-shot pulse engine: captures a bit mask and holds busy for len clocks,
// counting down; start requests while busy or with len==0 are dropped.
module nios2_pio_pulse_timer
    import nios2_pio_pkg::*;
#(
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned PULSE_CNT_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       start,
    input  logic [PULSE_CNT_WIDTH-1:0] len,
    input  logic [DATA_WIDTH-1:0]      mask_in,
    output logic                       busy,
    output logic [PULSE_CNT_WIDTH-1:0] cnt,
    output logic [DATA_WIDTH-1:0]      mask_out
);

    localparam logic [PULSE_CNT_WIDTH-1:0] CNT_ONE = PULSE_CNT_WIDTH'(1);

    pulse_state_e                state_q, state_d;
    logic [PULSE_CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]       mask_q, mask_d;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mask_q  <= mask_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mask_d  = mask_q;
        unique case (state_q)
            IDLE: begin
                if (start && (len != '0)) begin
                    state_d = PULSE;
                    cnt_d   = len;
                    mask_d  = mask_in;
                end
            end
            PULSE: begin
                // Last busy cycle is the one where cnt reads 1.
                if (cnt_q == CNT_ONE) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy     = (state_q == PULSE);
    assign cnt      = cnt_q;
    assign mask_out = mask_q;

endmodule

// File: rtl/nios2_data_out_pio.sv
// Avalon-MM output PIO: data register with atomic set/clear, registered
// read-back, and a timed bit-inversion pulse applied on out_port.
module nios2_data_out_pio
    import nios2_pio_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH      = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE     = '0,
    parameter int unsigned           PULSE_CNT_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [2:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [DATA_WIDTH-1:0] writedata,
    output logic [DATA_WIDTH-1:0] readdata,
    output logic [DATA_WIDTH-1:0] out_port
);

    localparam int unsigned BUSY_BIT = status_busy_bit(DATA_WIDTH);

    logic                       wr;
    logic [DATA_WIDTH-1:0]      data_q, data_d;
    logic [PULSE_CNT_WIDTH-1:0] plen_q, plen_d;
    logic [DATA_WIDTH-1:0]      rd_q, rd_d;
    logic [DATA_WIDTH-1:0]      status;
    logic                       busy;
    logic [PULSE_CNT_WIDTH-1:0] cnt;
    logic [DATA_WIDTH-1:0]      pmask;

    assign wr = chipselect && !write_n;

    nios2_pio_pulse_timer #(
        .DATA_WIDTH      (DATA_WIDTH),
        .PULSE_CNT_WIDTH (PULSE_CNT_WIDTH)
    ) u_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (wr && (address == ADDR_PULSE)),
        .len      (plen_q),
        .mask_in  (writedata),
        .busy     (busy),
        .cnt      (cnt),
        .mask_out (pmask)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            data_q <= RESET_VALUE;
            plen_q <= '0;
            rd_q   <= '0;
        end else begin
            data_q <= data_d;
            plen_q <= plen_d;
            rd_q   <= rd_d;
        end
    end

    always_comb begin
        data_d = data_q;
        plen_d = plen_q;
        if (wr) begin
            unique case (address)
                ADDR_DATA:   data_d = writedata;
                ADDR_OUTSET: data_d = data_q | writedata;
                ADDR_OUTCLR: data_d = data_q & ~writedata;
                ADDR_PLEN:   plen_d = writedata[PULSE_CNT_WIDTH-1:0];
                default:     ;
            endcase
        end
    end

    always_comb begin
        status = '0;
        status[BUSY_BIT] = busy;
        status[STATUS_CNT_LSB +: PULSE_CNT_WIDTH] = cnt;
    end

    // Read mux samples pre-write register values, so same-cycle reads see old data.
    always_comb begin
        rd_d = '0;
        unique case (address)
            ADDR_DATA:  rd_d = data_q;
            ADDR_PLEN:  rd_d[PULSE_CNT_WIDTH-1:0] = plen_q;
            ADDR_PULSE: rd_d = status;
            default:    rd_d = '0;
        endcase
    end

    assign readdata = rd_q;
    assign out_port = data_q ^ (busy ? pmask : '0);

endmodule

// File: tb/tb_nios2_data_out_pio.sv
// Scoreboard bench for nios2_data_out_pio: stimulus queues the expected
// post-edge out_port/readdata, a monitor pops and compares after each edge.
module tb_nios2_data_out_pio;

    localparam logic [31:0] RV = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  address = 3'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic [31:0] out_port;

    int checks = 0;
    int failures = 0;

    typedef struct {
        string       name;
        bit          co;
        logic [31:0] eo;
        bit          cr;
        logic [31:0] er;
    } exp_t;

    exp_t sb[$];

    nios2_data_out_pio #(
        .DATA_WIDTH      (32),
        .RESET_VALUE     (RV),
        .PULSE_CNT_WIDTH (16)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port)
    );

    always #5 clk = ~clk;

    // Monitor: one scoreboard entry describes the state just after each edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                if (e.co) begin
                    checks++;
                    if (out_port !== e.eo) begin
                        failures++;
                        $display("FAIL %s out_port got %h expected %h", e.name, out_port, e.eo);
                    end
                end
                if (e.cr) begin
                    checks++;
                    if (readdata !== e.er) begin
                        failures++;
                        $display("FAIL %s readdata got %h expected %h", e.name, readdata, e.er);
                    end
                end
            end
        end
    end

    // Drive one cycle of bus inputs and queue what must be seen after the edge.
    task automatic step(input logic rst_n, input logic [2:0] a, input logic wr,
                        input logic [31:0] wd, input string nm,
                        input bit co, input logic [31:0] eo,
                        input bit cr, input logic [31:0] er);
        exp_t e;
        @(negedge clk);
        reset_n    = rst_n;
        address    = a;
        chipselect = wr;
        write_n    = ~wr;
        writedata  = wd;
        e.name = nm; e.co = co; e.eo = eo; e.cr = cr; e.er = er;
        sb.push_back(e);
    endtask

    initial begin
        // Reset, then read-back of RESET_VALUE
        step(0, 3'd0, 0, '0, "rst1", 1, RV, 1, 32'h0);
        step(0, 3'd0, 0, '0, "rst2", 1, RV, 1, 32'h0);
        step(1, 3'd0, 0, '0, "rd_rv", 1, RV, 1, RV);

        // Set / clear
        step(1, 3'd0, 1, 32'h0000_00F0, "wr_data", 1, 32'h0000_00F0, 1, RV);
        step(1, 3'd4, 1, 32'h0000_000F, "outset",  1, 32'h0000_00FF, 1, 32'h0);
        step(1, 3'd5, 1, 32'h0000_0030, "outclr",  1, 32'h0000_00CF, 1, 32'h0);
        step(1, 3'd0, 0, '0,            "rd_cf",   1, 32'h0000_00CF, 1, 32'h0000_00CF);

        // Single 5-cycle pulse
        step(1, 3'd0, 1, 32'h0,         "data0",   1, 32'h0, 1, 32'h0000_00CF);
        step(1, 3'd1, 1, 32'h5,         "plen5",   1, 32'h0, 1, 32'h0);
        step(1, 3'd2, 1, 32'h8000_0001, "start5",  1, 32'h8000_0001, 1, 32'h0);
        for (int k = 1; k <= 5; k++)
            step(1, 3'd2, 0, '0, $sformatf("p5_c%0d", k),
                 1, (k <= 4) ? 32'h8000_0001 : 32'h0,
                 1, 32'h8000_0000 | 32'(6 - k));
        step(1, 3'd2, 0, '0, "p5_done", 1, 32'h0, 1, 32'h0);

        // PLEN=0 start is ignored
        step(1, 3'd1, 1, 32'h0,         "plen0",   1, 32'h0, 1, 32'h5);
        step(1, 3'd2, 1, 32'hFFFF_FFFF, "start0",  1, 32'h0, 1, 32'h0);
        step(1, 3'd2, 0, '0,            "st0_idle",1, 32'h0, 1, 32'h0);

        // Restart attempt during a 10-cycle pulse is ignored
        step(1, 3'd1, 1, 32'hA,         "plen10",  1, 32'h0, 1, 32'h0);
        step(1, 3'd2, 1, 32'h1,         "start10", 1, 32'h1, 1, 32'h0);
        step(1, 3'd2, 0, '0,            "p10_c1",  1, 32'h1, 1, 32'h8000_000A);
        step(1, 3'd2, 1, 32'hFF,        "p10_rst", 1, 32'h1, 1, 32'h8000_0009);
        for (int k = 3; k <= 10; k++)
            step(1, 3'd2, 0, '0, $sformatf("p10_c%0d", k),
                 1, (k <= 9) ? 32'h1 : 32'h0,
                 1, 32'h8000_0000 | 32'(11 - k));

        // DATA write during an 8-cycle pulse
        step(1, 3'd1, 1, 32'h8,         "plen8",   1, 32'h0, 1, 32'hA);
        step(1, 3'd2, 1, 32'h1,         "start8",  1, 32'h1, 1, 32'h0);
        step(1, 3'd0, 0, '0,            "p8_c1",   1, 32'h1, 1, 32'h0);
        step(1, 3'd0, 1, 32'h3,         "p8_wr3",  1, 32'h2, 1, 32'h0);
        for (int k = 3; k <= 8; k++)
            step(1, 3'd0, 0, '0, $sformatf("p8_c%0d", k),
                 1, (k <= 7) ? 32'h2 : 32'h3, 1, 32'h3);

        // Reset mid-pulse
        step(1, 3'd1, 1, 32'h14,        "plen20",  1, 32'h3, 1, 32'h8);
        step(1, 3'd2, 1, 32'h1,         "start20", 1, 32'h2, 1, 32'h0);
        for (int k = 1; k <= 3; k++)
            step(1, 3'd2, 0, '0, $sformatf("p20_c%0d", k),
                 1, 32'h2, 1, 32'h8000_0000 | 32'(21 - k));
        step(0, 3'd2, 1, 32'hFF,        "p20_reset",1, RV, 1, 32'h0);
        step(1, 3'd2, 0, '0,            "post_rst", 1, RV, 1, 32'h0);
        step(1, 3'd2, 1, 32'hFFFF_FFFF, "start_pl0",1, RV, 1, 32'h0);
        step(1, 3'd2, 0, '0,            "still_idle",1, RV, 1, 32'h0);
        step(1, 3'd1, 0, '0,            "plen_clr", 1, RV, 1, 32'h0);

        // Unmapped addresses: writes ignored, reads zero
        step(1, 3'd3, 1, 32'h1234_5678, "wr_a3",   1, RV, 1, 32'h0);
        step(1, 3'd6, 1, 32'h1234_5678, "wr_a6",   1, RV, 1, 32'h0);
        step(1, 3'd7, 1, 32'h1234_5678, "wr_a7",   1, RV, 1, 32'h0);
        step(1, 3'd0, 0, '0,            "rd_after",1, RV, 1, RV);

        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain scoreboard left %0d expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
